// File: rtl/mod_exp_engine_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the modular exponentiation engine and its
// bit-serial modular multiplier.
//   state_t       : top-level FSM encoding
//   DEFAULT_WIDTH : default operand width
//   clog2()       : ceiling log2, used to size iteration counters
// ---------------------------------------------------------------------------
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    MUL,
    CHECK,
    SQR,
    FIN
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_mul_seq.sv
// ---------------------------------------------------------------------------
// mod_mul_seq
// Bit-serial interleaved (Blakley) modular multiplier: p = a*b mod n.
// Scans a MSB first; each iteration doubles the partial product, adds b when
// the current bit of a is set, then subtracts n at most twice so the partial
// product stays below n.  Requires b < n and n >= 2; a may be any value.
// Fixed latency: start sampled in cycle s, done pulses in cycle s+WIDTH+1.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (control state only)
//   start in   one-cycle request, honoured only while busy=0
//   a     in   WIDTH multiplier (scanned MSB first)
//   b     in   WIDTH multiplicand, must be < n
//   n     in   WIDTH modulus, must be >= 2
//   busy  out  high while iterating
//   done  out  one-cycle pulse, p valid in that cycle
//   p     out  WIDTH product mod n, held until the next start
// ---------------------------------------------------------------------------
module mod_mul_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  // One issue cycle, WIDTH iterations, one capture cycle.
  localparam int MUL_CYC = WIDTH + 2;
  localparam int CNT_W   = clog2(MUL_CYC);
  // 2p + b < 3n < 2^(WIDTH+2), so two guard bits suffice.
  localparam int EXT_W   = WIDTH + 2;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [EXT_W-1:0] r_p;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             w_load;

  // One Blakley iteration; input partial product is always < n.
  function automatic logic [EXT_W-1:0] blakley_step(
    input logic [EXT_W-1:0] acc,
    input logic             bit_i,
    input logic [WIDTH-1:0] addend,
    input logic [WIDTH-1:0] modn
  );
    logic [EXT_W-1:0] t;
    logic [EXT_W-1:0] nx;
    nx = {2'b00, modn};
    t  = {acc[EXT_W-2:0], 1'b0} + (bit_i ? {2'b00, addend} : '0);
    if (t >= nx) t = t - nx;
    if (t >= nx) t = t - nx;
    return t;
  endfunction

  assign w_load = start && !r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_busy <= 1'b1;
        r_cnt  <= CNT_W'(MUL_CYC - 2);
      end else if (r_busy) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a <= a;
      r_b <= b;
      r_n <= n;
      r_p <= '0;
    end else if (r_busy) begin
      r_p <= blakley_step(r_p, r_a[WIDTH-1], r_b, r_n);
      r_a <= {r_a[WIDTH-2:0], 1'b0};
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p[WIDTH-1:0];

endmodule

// File: rtl/mod_exp_engine.sv
// ---------------------------------------------------------------------------
// mod_exp_engine
// Sequential modular exponentiation: result = base^exponent mod modulus,
// right-to-left binary square-and-multiply over mod_mul_seq.
//   REDUCE : b = base*1 mod n (issued directly from IDLE), acc = 1
//   MUL    : acc = acc*b mod n when the current exponent bit is set
//   CHECK  : exponent exhausted -> FIN, otherwise issue b = b*b mod n
//   SQR    : wait for the square
// Multiplies run back to back, each occupying WIDTH+2 cycles, so the
// start-to-done latency is (WIDTH+2)*(number of multiplies) + 1.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, aborts any operation
//   start    in   one-cycle request, sampled only while idle
//   base     in   WIDTH base, any value
//   exponent in   WIDTH exponent
//   modulus  in   WIDTH modulus, >= 2 for a valid result
//   busy     out  high from the cycle after an accepted start until done
//   done     out  one-cycle pulse; result/error valid
//   result   out  WIDTH base^exponent mod modulus, held
//   error    out  modulus < 2 on the last operation, held with result
// ---------------------------------------------------------------------------
module mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_error;
  logic             r_done;

  logic             w_accept;
  logic             w_finish;
  logic             w_err;
  logic             w_cap_b;
  logic             w_cap_acc;
  logic             w_e_shift;

  logic             w_mul_start;
  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH-1:0] w_mul_b;
  logic [WIDTH-1:0] w_mul_n;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_p;

  mod_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(w_mul_start),
    .a    (w_mul_a),
    .b    (w_mul_b),
    .n    (w_mul_n),
    .busy (w_mul_busy),
    .done (w_mul_done),
    .p    (w_mul_p)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_err       = 1'b0;
    w_cap_b     = 1'b0;
    w_cap_acc   = 1'b0;
    w_e_shift   = 1'b0;
    w_mul_start = 1'b0;
    w_mul_a     = r_b;
    w_mul_b     = r_b;
    w_mul_n     = r_n;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (modulus < WIDTH'(2)) begin
            w_err       = 1'b1;
            w_finish    = 1'b1;
            w_state_nxt = FIN;
          end else begin
            // Reduction is issued straight from the live inputs so the
            // first multiply starts in the accept cycle.
            w_mul_start = 1'b1;
            w_mul_a     = base;
            w_mul_b     = WIDTH'(1);
            w_mul_n     = modulus;
            w_state_nxt = REDUCE;
          end
        end
      end

      REDUCE, SQR: begin
        if (w_mul_done) begin
          w_cap_b = 1'b1;
          if (r_e[0]) begin
            w_state_nxt = MUL;
          end else begin
            w_e_shift   = 1'b1;
            w_state_nxt = CHECK;
          end
        end
      end

      MUL: begin
        w_mul_a = r_acc;
        // Issue in the first MUL cycle: the multiplier has just finished.
        if (!w_mul_busy && !w_mul_done) w_mul_start = 1'b1;
        if (w_mul_done) begin
          w_cap_acc   = 1'b1;
          w_e_shift   = 1'b1;
          w_state_nxt = CHECK;
        end
      end

      CHECK: begin
        if (r_e == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = FIN;
        end else begin
          w_mul_start = 1'b1;
          w_state_nxt = SQR;
        end
      end

      FIN: w_state_nxt = IDLE;

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_done   <= 1'b0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_finish;
      if (w_finish) begin
        r_result <= w_err ? '0 : r_acc;
        r_error  <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_e   <= exponent;
      r_n   <= modulus;
      r_b   <= base;
      r_acc <= WIDTH'(1);
    end else begin
      if (w_cap_b)   r_b   <= w_mul_p;
      if (w_cap_acc) r_acc <= w_mul_p;
      if (w_e_shift) r_e   <= r_e >> 1;
    end
  end

  assign busy   = (r_state != IDLE) && (r_state != FIN);
  assign done   = r_done;
  assign result = r_result;
  assign error  = r_error;

endmodule
